oled_text_renderer: RTL and testbench

Sequencer that turns a line of ASCII characters into an SSD1306 byte stream for a two-page (8x16) font. Holds a NUM_CHARS character buffer and walks it column by column, driving the font ROM's ascii/index/font_row inputs and capturing its registered output. Emits page/column address commands and glyph data bytes to the downstream OLED byte writer over a valid/ready handshake.

---
 rtl/oled_text_renderer.sv | 220 ++++++++++++++++++++++
 tb/tb_oled_text_renderer.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_text_renderer.sv
// -----------------------------------------------------------------------------
// oled_text_renderer
//
// Turns a line of ASCII characters into an SSD1306 byte stream for an 8x16
// font that spans two OLED pages. The character buffer is walked column by
// column: for each glyph column the external font ROM is addressed, its
// registered output is captured, and the byte is handed to the OLED byte
// writer. Each half-line (page) is preceded by page/column address commands.
//
// Ports:
//   clk_50m      system clock
//   rst_n        asynchronous active-low reset
//   wr_en        write wr_char into buffer slot wr_addr (ignored while busy)
//   wr_addr      buffer slot index (slots >= NUM_CHARS are ignored)
//   wr_char      ASCII code
//   start        single-cycle pulse, begin rendering (accepted only when idle)
//   busy         high from accepted start until done
//   done         single-cycle pulse after the last byte is accepted
//   font_ascii   font ROM character code
//   font_row     font ROM half select (0 = upper page, 1 = lower page)
//   font_index   font ROM column index (0..7)
//   font_data    font ROM registered output, valid one cycle after address
//   byte_out     byte to the OLED writer
//   byte_dc      0 = command byte, 1 = display data byte
//   byte_valid   byte_out/byte_dc valid
//   byte_ready   downstream accepts when byte_valid && byte_ready
// -----------------------------------------------------------------------------
module oled_text_renderer #(
   parameter int NUM_CHARS  = 16,
   parameter int START_PAGE = 0,
   parameter int START_COL  = 0,
   parameter int AW         = $clog2(NUM_CHARS)
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_char,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [7:0]    font_ascii,
   output logic          font_row,
   output logic [4:0]    font_index,
   input  logic [7:0]    font_data,
   output logic [7:0]    byte_out,
   output logic          byte_dc,
   output logic          byte_valid,
   input  logic          byte_ready
);

   if (START_COL + 8 * NUM_CHARS > 128) begin : g_bad_width
      $error("oled_text_renderer: START_COL + 8*NUM_CHARS exceeds 128 columns");
   end
   if (START_PAGE < 0 || START_PAGE > 6) begin : g_bad_page
      $error("oled_text_renderer: START_PAGE must be 0..6");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] LAST_CHAR = AW'(NUM_CHARS - 1);
   localparam logic [2:0]    PAGE_BASE = 3'(START_PAGE);
   localparam logic [3:0]    COL_LO    = 4'(START_COL % 16);
   localparam logic [2:0]    COL_HI    = 3'(START_COL / 16);

   state_t        state_q, state_d;
   logic          row_q, row_d;
   logic [AW-1:0] char_q, char_d;
   logic [2:0]    idx_q, idx_d;
   logic [1:0]    cmd_q, cmd_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    char_buf_q [NUM_CHARS];
   logic [7:0]    char_buf_d [NUM_CHARS];
   logic [2:0]    page;

   // Character buffer: writes land only while not rendering, so the line
   // cannot change underneath an in-flight stream.
   always_comb begin : p_buf
      char_buf_d = char_buf_q;
      if (wr_en && (state_q == S_IDLE || state_q == S_DONE)
          && ({1'b0, wr_addr} < (AW+1)'(NUM_CHARS))) begin
         char_buf_d[wr_addr] = wr_char;
      end
   end

   // Next-state and output decode.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin : p_next
      state_d    = state_q;
      row_d      = row_q;
      char_d     = char_q;
      idx_d      = idx_q;
      cmd_d      = cmd_q;
      data_d     = data_q;
      busy       = 1'b0;
      done       = 1'b0;
      font_ascii = 8'h00;
      font_row   = 1'b0;
      font_index = 5'd0;
      byte_out   = 8'h00;
      byte_dc    = 1'b0;
      byte_valid = 1'b0;
      page       = PAGE_BASE + {2'b00, row_q};

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CMD;
               row_d   = 1'b0;
               cmd_d   = 2'd0;
            end
         end

         S_CMD: begin
            busy       = 1'b1;
            byte_valid = 1'b1;
            case (cmd_q)
               2'd0:    byte_out = {5'b10110, page};    // set page (B0 | page)
               2'd1:    byte_out = {4'h0, COL_LO};      // column low nibble
               default: byte_out = {5'b00010, COL_HI};  // column high bits
            endcase
            if (byte_ready) begin
               if (cmd_q == 2'd2) begin
                  state_d = S_FETCH;
                  char_d  = '0;
                  idx_d   = 3'd0;
               end else begin
                  cmd_d = cmd_q + 2'd1;
               end
            end
         end

         // FETCH presents the ROM address; WAIT holds it while the ROM's
         // registered output settles, then captures it for SEND.
         S_FETCH: begin
            busy       = 1'b1;
            font_ascii = char_buf_q[char_q];
            font_row   = row_q;
            font_index = {2'b00, idx_q};
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            busy       = 1'b1;
            font_ascii = char_buf_q[char_q];
            font_row   = row_q;
            font_index = {2'b00, idx_q};
            data_d     = font_data;
            state_d    = S_SEND;
         end

         S_SEND: begin
            busy       = 1'b1;
            byte_out   = data_q;
            byte_dc    = 1'b1;
            byte_valid = 1'b1;
            if (byte_ready) begin
               if (idx_q == 3'd7) begin
                  idx_d = 3'd0;
                  if (char_q == LAST_CHAR) begin
                     if (!row_q) begin
                        state_d = S_CMD;
                        row_d   = 1'b1;
                        cmd_d   = 2'd0;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     char_d  = char_q + AW'(1);
                     state_d = S_FETCH;
                  end
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_FETCH;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the buffer is reset slot by slot so a reset always yields a line
   // of spaces; a memory without reset would come up with garbage glyphs.
   always_ff @(posedge clk_50m or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= 1'b0;
         char_q  <= '0;
         idx_q   <= 3'd0;
         cmd_q   <= 2'd0;
         data_q  <= 8'h00;
         for (int i = 0; i < NUM_CHARS; i++) begin
            char_buf_q[i] <= 8'h20;
         end
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         char_q     <= char_d;
         idx_q      <= idx_d;
         cmd_q      <= cmd_d;
         data_q     <= data_d;
         char_buf_q <= char_buf_d;
      end
   end

endmodule

// File: tb/tb_oled_text_renderer.sv
// -----------------------------------------------------------------------------
// tb_oled_text_renderer
//
// Directed bench for oled_text_renderer. A small font ROM model feeds each
// instance; a negedge monitor captures every accepted byte. One task per
// scenario drives stimulus and compares against hand-written constants and a
// stream built from the bench's own copy of the character buffer.
// -----------------------------------------------------------------------------
module tb_oled_text_renderer;

   logic       clk_50m = 1'b0;
   always #10 clk_50m = ~clk_50m;

   // main instance: defaults (16 chars, page 0, column 0)
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_char;
   logic       start;
   logic       busy, done;
   logic [7:0] font_ascii;
   logic       font_row;
   logic [4:0] font_index;
   logic [7:0] font_data;
   logic [7:0] byte_out;
   logic       byte_dc, byte_valid;
   logic       byte_ready;

   // second instance: 5 chars, page 2, column 37
   logic       wr_en2;
   logic [2:0] wr_addr2;
   logic [7:0] wr_char2;
   logic       start2;
   logic       busy2, done2;
   logic [7:0] font_ascii2;
   logic       font_row2;
   logic [4:0] font_index2;
   logic [7:0] font_data2;
   logic [7:0] byte_out2;
   logic       byte_dc2, byte_valid2;
   logic       byte_ready2;

   oled_text_renderer u_dut (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_char    (wr_char),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .font_ascii (font_ascii),
      .font_row   (font_row),
      .font_index (font_index),
      .font_data  (font_data),
      .byte_out   (byte_out),
      .byte_dc    (byte_dc),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready)
   );

   oled_text_renderer #(
      .NUM_CHARS  (5),
      .START_PAGE (2),
      .START_COL  (37)
   ) u_dut2 (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .wr_en      (wr_en2),
      .wr_addr    (wr_addr2),
      .wr_char    (wr_char2),
      .start      (start2),
      .busy       (busy2),
      .done       (done2),
      .font_ascii (font_ascii2),
      .font_row   (font_row2),
      .font_index (font_index2),
      .font_data  (font_data2),
      .byte_out   (byte_out2),
      .byte_dc    (byte_dc2),
      .byte_valid (byte_valid2),
      .byte_ready (byte_ready2)
   );

   int total = 0;
   int bad   = 0;

   // Font model: space is blank, '0' and '1' use real glyphs, anything else
   // gets a recognisable synthetic pattern.
   function automatic logic [7:0] font_fn(input logic [7:0] a, input logic r,
                                          input logic [4:0] i);
      logic [63:0] g;
      int          col;
      col = int'(i[2:0]);
      if (a == 8'h20) return 8'h00;
      if (a == 8'h30) begin
         g = r ? 64'h000F_1020_2010_0F00 : 64'h00E0_1008_0810_E000;
         return g[8*(7-col) +: 8];
      end
      if (a == 8'h31) begin
         g = r ? 64'h0000_2020_3F20_2000 : 64'h0000_1010_F800_0000;
         return g[8*(7-col) +: 8];
      end
      return {a[3:0], r, i[2:0]};
   endfunction

   always @(posedge clk_50m) font_data  <= font_fn(font_ascii,  font_row,  font_index);
   always @(posedge clk_50m) font_data2 <= font_fn(font_ascii2, font_row2, font_index2);

   // byte_ready driver: tied high unless backpressure is enabled
   bit bp_en = 1'b0;
   always @(posedge clk_50m) begin
      #1;
      byte_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: capture accepted bytes, count done pulses, check stall stability
   logic [8:0] cap_q  [$];
   logic [8:0] cap2_q [$];
   logic [8:0] exp_q  [$];
   int         done_cnt  = 0;
   int         done2_cnt = 0;
   int         stab_err  = 0;
   bit         stall_prev = 1'b0;
   logic [8:0] prev_b;

   always @(negedge clk_50m) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && (!byte_valid || {byte_dc, byte_out} !== prev_b)) stab_err++;
         stall_prev = byte_valid && !byte_ready;
         prev_b     = {byte_dc, byte_out};
         if (byte_valid && byte_ready) cap_q.push_back({byte_dc, byte_out});
         if (done) done_cnt++;
         if (byte_valid2 && byte_ready2) cap2_q.push_back({byte_dc2, byte_out2});
         if (done2) done2_cnt++;
      end
   end

   // bench copies of the character buffers
   logic [7:0] mbuf  [16];
   logic [7:0] mbuf2 [5];

   task automatic build_exp(input int page, input int col, input int n, input bit second);
      logic [7:0] ch;
      exp_q.delete();
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back({1'b0, 8'hB0 | 8'(page + r)});
         exp_q.push_back({1'b0, 8'(col % 16)});
         exp_q.push_back({1'b0, 8'h10 | 8'(col / 16)});
         for (int c = 0; c < n; c++) begin
            ch = second ? mbuf2[c] : mbuf[c];
            for (int i = 0; i < 8; i++) begin
               exp_q.push_back({1'b1, font_fn(ch, r[0], 5'(i))});
            end
         end
      end
   endtask

   // first index where a capture differs from exp_q (-1 if identical)
   task automatic diff_stream(input bit second, output int idx,
                              output logic [8:0] got, output logic [8:0] want);
      int n;
      idx  = -1;
      got  = '0;
      want = '0;
      n = second ? cap2_q.size() : cap_q.size();
      for (int k = 0; k < exp_q.size(); k++) begin
         got  = (k < n) ? (second ? cap2_q[k] : cap_q[k]) : 9'h1FF;
         want = exp_q[k];
         if (got !== want) begin
            idx = k;
            return;
         end
      end
      if (n != exp_q.size()) begin
         idx  = exp_q.size();
         got  = 9'h1FF;
         want = 9'h1FF;
      end
   endtask

   function automatic logic [8:0] cap_at(input int k);
      return (k < cap_q.size()) ? cap_q[k] : 9'h1FF;
   endfunction

   function automatic logic [8:0] cap2_at(input int k);
      return (k < cap2_q.size()) ? cap2_q[k] : 9'h1FF;
   endfunction

   task automatic start_render(input bit wr, input logic [3:0] a, input logic [7:0] c);
      cap_q.delete();
      done_cnt = 0;
      stab_err = 0;
      @(negedge clk_50m);
      start = 1'b1;
      if (wr) begin
         wr_en   = 1'b1;
         wr_addr = a;
         wr_char = c;
      end
      @(negedge clk_50m);
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   // wait for done; at cycle inject_at pulse start and a write to slot 0
   task automatic wait_done(input int inject_at, output int busy_err, output bit timed_out);
      busy_err  = 0;
      timed_out = 1'b1;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk_50m);
         if (done) begin
            timed_out = 1'b0;
            break;
         end
         if (!busy) busy_err++;
         if (k == inject_at) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_char = "7";
         end else begin
            start = 1'b0;
            wr_en = 1'b0;
         end
      end
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] c);
      @(negedge clk_50m);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_char = c;
      @(negedge clk_50m);
      wr_en = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_char = '0; start = 1'b0;
      wr_en2 = 1'b0; wr_addr2 = '0; wr_char2 = '0; start2 = 1'b0;
      byte_ready = 1'b1; byte_ready2 = 1'b1;
      for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
      for (int i = 0; i < 5; i++) mbuf2[i] = 8'h20;
      repeat (3) @(negedge clk_50m);
      total++;
      if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++;
      if ({byte_dc, byte_out} !== 9'h000) begin
         bad++; $display("FAIL reset_byte: got %h want 000", {byte_dc, byte_out});
      end
      total++;
      if ({font_ascii, font_row, font_index} !== 14'h0) begin
         bad++; $display("FAIL reset_font: got %h want 0", {font_ascii, font_row, font_index});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk_50m);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_blank_render();
      int busy_err, idx;
      bit to;
      logic [8:0] got, want;
      build_exp(0, 0, 16, 1'b0);
      start_render(1'b0, 4'd0, 8'h00);
      wait_done(-1, busy_err, to);
      repeat (3) @(negedge clk_50m);
      total++;
      if (to) begin bad++; $display("FAIL blank_timeout: got no done want done"); end
      total++;
      if (busy_err != 0) begin bad++; $display("FAIL blank_busy: got %0d low cycles want 0", busy_err); end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL blank_done_count: got %0d want 1", done_cnt); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL blank_busy_after: got %b want 0", busy); end
      total++;
      if ({cap_at(0), cap_at(1), cap_at(2)} !== {9'h0B0, 9'h000, 9'h010}) begin
         bad++; $display("FAIL blank_cmd_row0: got %h %h %h want 0b0 000 010",
                         cap_at(0), cap_at(1), cap_at(2));
      end
      total++;
      if ({cap_at(131), cap_at(132), cap_at(133)} !== {9'h0B1, 9'h000, 9'h010}) begin
         bad++; $display("FAIL blank_cmd_row1: got %h %h %h want 0b1 000 010",
                         cap_at(131), cap_at(132), cap_at(133));
      end
      total++;
      if (cap_q.size() != 262) begin bad++; $display("FAIL blank_length: got %0d want 262", cap_q.size()); end
      diff_stream(1'b0, idx, got, want);
      total++;
      if (idx != -1) begin bad++; $display("FAIL blank_stream: at %0d got %h want %h", idx, got, want); end
   endtask

   task automatic test_digits();
      int busy_err, idx, dc_err, e0, e1, e2;
      bit to;
      logic [8:0] got, want;
      logic [63:0] r0c0, r0c1, r1c0;
      r0c0 = 64'h00E0_1008_0810_E000;
      r0c1 = 64'h0000_1010_F800_0000;
      r1c0 = 64'h000F_1020_2010_0F00;
      for (int i = 0; i < 9; i++) begin
         do_write(4'(i), 8'h30 + 8'(i));
         mbuf[i] = 8'h30 + 8'(i);
      end
      // slot 9 written in the same cycle as start must be rendered
      mbuf[9] = "9";
      build_exp(0, 0, 16, 1'b0);
      start_render(1'b1, 4'd9, "9");
      wait_done(-1, busy_err, to);
      repeat (3) @(negedge clk_50m);
      total++;
      if (to || done_cnt != 1) begin
         bad++; $display("FAIL digits_done: got timeout=%0d done=%0d want 0 1", to, done_cnt);
      end
      e0 = 0; e1 = 0; e2 = 0; dc_err = 0;
      for (int j = 0; j < 8; j++) begin
         if (cap_at(3 + j)   !== {1'b1, r0c0[8*(7-j) +: 8]}) e0++;
         if (cap_at(11 + j)  !== {1'b1, r0c1[8*(7-j) +: 8]}) e1++;
         if (cap_at(134 + j) !== {1'b1, r1c0[8*(7-j) +: 8]}) e2++;
      end
      total++;
      if (e0 != 0) begin bad++; $display("FAIL digits_r0_char0: got %0d wrong bytes want 0", e0); end
      total++;
      if (e1 != 0) begin bad++; $display("FAIL digits_r0_char1: got %0d wrong bytes want 0", e1); end
      total++;
      if (e2 != 0) begin bad++; $display("FAIL digits_r1_char0: got %0d wrong bytes want 0", e2); end
      for (int k = 0; k < cap_q.size(); k++) begin
         if (cap_q[k][8] !== ((k % 131) >= 3)) dc_err++;
      end
      total++;
      if (dc_err != 0) begin bad++; $display("FAIL digits_dc: got %0d wrong dc flags want 0", dc_err); end
      diff_stream(1'b0, idx, got, want);
      total++;
      if (idx != -1) begin bad++; $display("FAIL digits_stream: at %0d got %h want %h", idx, got, want); end
   endtask

   task automatic test_backpressure();
      int busy_err, idx;
      bit to;
      logic [8:0] got, want;
      build_exp(0, 0, 16, 1'b0);
      bp_en = 1'b1;
      start_render(1'b0, 4'd0, 8'h00);
      wait_done(-1, busy_err, to);
      bp_en = 1'b0;
      repeat (3) @(negedge clk_50m);
      total++;
      if (to || done_cnt != 1) begin
         bad++; $display("FAIL bp_done: got timeout=%0d done=%0d want 0 1", to, done_cnt);
      end
      total++;
      if (stab_err != 0) begin bad++; $display("FAIL bp_stable: got %0d changes under stall want 0", stab_err); end
      diff_stream(1'b0, idx, got, want);
      total++;
      if (idx != -1) begin bad++; $display("FAIL bp_stream: at %0d got %h want %h", idx, got, want); end
   endtask

   task automatic test_busy_ignore();
      int busy_err, idx;
      bit to;
      logic [8:0] got, want;
      build_exp(0, 0, 16, 1'b0);
      start_render(1'b0, 4'd0, 8'h00);
      wait_done(40, busy_err, to);
      repeat (6) @(negedge clk_50m);
      total++;
      if (to || done_cnt != 1 || busy !== 1'b0) begin
         bad++; $display("FAIL ignore_done: got timeout=%0d done=%0d busy=%b want 0 1 0", to, done_cnt, busy);
      end
      diff_stream(1'b0, idx, got, want);
      total++;
      if (idx != -1) begin bad++; $display("FAIL ignore_stream: at %0d got %h want %h", idx, got, want); end
      // re-render: slot 0 must still hold '0'
      start_render(1'b0, 4'd0, 8'h00);
      wait_done(-1, busy_err, to);
      repeat (3) @(negedge clk_50m);
      total++;
      if (cap_at(4) !== 9'h1E0) begin bad++; $display("FAIL ignore_slot0: got %h want 1e0", cap_at(4)); end
      diff_stream(1'b0, idx, got, want);
      total++;
      if (idx != -1) begin bad++; $display("FAIL rerender_stream: at %0d got %h want %h", idx, got, want); end
   endtask

   task automatic test_reset_mid();
      int busy_err, idx;
      bit to, reached;
      logic [8:0] got, want;
      start_render(1'b0, 4'd0, 8'h00);
      reached = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk_50m);
         if (cap_q.size() >= 50) begin
            reached = 1'b1;
            break;
         end
      end
      total++;
      if (!reached) begin bad++; $display("FAIL midreset_reach: got %0d bytes want 50", cap_q.size()); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, byte_valid, byte_dc, byte_out} !== 12'h000) begin
         bad++; $display("FAIL midreset_outputs: got %h want 000", {busy, done, byte_valid, byte_dc, byte_out});
      end
      total++;
      if ({font_ascii, font_row, font_index} !== 14'h0) begin
         bad++; $display("FAIL midreset_font: got %h want 0", {font_ascii, font_row, font_index});
      end
      repeat (3) @(negedge clk_50m);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_50m);
      total++;
      if (done_cnt != 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt); end
      for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
      build_exp(0, 0, 16, 1'b0);
      start_render(1'b0, 4'd0, 8'h00);
      wait_done(-1, busy_err, to);
      repeat (3) @(negedge clk_50m);
      diff_stream(1'b0, idx, got, want);
      total++;
      if (to || idx != -1) begin
         bad++; $display("FAIL midreset_cleared: timeout=%0d at %0d got %h want %h", to, idx, got, want);
      end
   endtask

   task automatic test_params();
      int idx;
      bit to;
      logic [8:0] got, want;
      // slot 7 is outside a 5-char line and must be dropped
      @(negedge clk_50m);
      wr_en2 = 1'b1; wr_addr2 = 3'd7; wr_char2 = "A";
      @(negedge clk_50m);
      wr_addr2 = 3'd4; wr_char2 = "1";
      @(negedge clk_50m);
      wr_en2 = 1'b0;
      mbuf2[4] = "1";
      build_exp(2, 37, 5, 1'b1);
      cap2_q.delete();
      done2_cnt = 0;
      start2 = 1'b1;
      @(negedge clk_50m);
      start2 = 1'b0;
      to = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk_50m);
         if (done2) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(negedge clk_50m);
      total++;
      if (to || done2_cnt != 1) begin
         bad++; $display("FAIL params_done: got timeout=%0d done=%0d want 0 1", to, done2_cnt);
      end
      total++;
      if ({cap2_at(0), cap2_at(1), cap2_at(2)} !== {9'h0B2, 9'h005, 9'h012}) begin
         bad++; $display("FAIL params_cmd_row0: got %h %h %h want 0b2 005 012",
                         cap2_at(0), cap2_at(1), cap2_at(2));
      end
      total++;
      if ({cap2_at(43), cap2_at(44), cap2_at(45)} !== {9'h0B3, 9'h005, 9'h012}) begin
         bad++; $display("FAIL params_cmd_row1: got %h %h %h want 0b3 005 012",
                         cap2_at(43), cap2_at(44), cap2_at(45));
      end
      total++;
      if (cap2_at(39) !== 9'h1F8) begin bad++; $display("FAIL params_slot4: got %h want 1f8", cap2_at(39)); end
      diff_stream(1'b1, idx, got, want);
      total++;
      if (idx != -1) begin bad++; $display("FAIL params_stream: at %0d got %h want %h", idx, got, want); end
   endtask

   initial begin
      test_reset();
      test_blank_render();
      test_digits();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_params();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
